// File: rtl/packet_pkg.sv
// Shared packet format, network-interface FSM states and default sizing for the optical NoC.
package packet_pkg;

  localparam int NI_DEFAULT_DEPTH   = 4;
  localparam int NI_DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [31:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } ni_state_t;

endpackage

// File: rtl/ni_fifo.sv
// Packet queue: registered head, count updates on the push/pop edge.
// Latency 1 cycle push-to-head; a push while full or a pop while empty is ignored.
module ni_fifo
  import packet_pkg::*;
#(
  parameter int DEPTH = NI_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  packet_t                    push_dat,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output packet_t                    head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ni_fifo DEPTH must be a power of two >= 2");
  end

  packet_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/onoc_net_iface.sv
// Network interface: queues IP packets, arbitrates for the waveguide, sends one at a time.
// Latency: request 1 cycle after push; backpressure via ready_out (not-full); optional ONOC_NI_TIMEOUT_EN drops stalled packets.
module onoc_net_iface
  import packet_pkg::*;
#(
  parameter int DEPTH   = NI_DEFAULT_DEPTH,
  parameter int TIMEOUT = NI_DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  packet_t                    data_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic                       request_to_send,
  input  logic                       permission_granted_send,
  input  logic                       packet_done,
  output packet_t                    data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                overflow_count,
  output logic [31:0]                drop_count
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("onoc_net_iface TIMEOUT must be >= 1");
  end

  ni_state_t state;
  ni_state_t next_state;
  logic      fifo_full;
  logic      fifo_empty;
  packet_t   fifo_head;
  logic      fifo_pop;
  logic      fire;

  ni_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (valid_in),
    .push_dat (data_in),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (occupancy)
  );

  assign ready_out       = !fifo_full;
  assign request_to_send = (state != IDLE);
  assign fire            = (state == REQ) && permission_granted_send;

`ifdef ONOC_NI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] timer;
  logic          expire;

  // Delivery wins over expiry when both land on the same cycle.
  assign expire = (state == WAIT_DONE) && !packet_done && (timer == TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      drop_count <= '0;
    end else begin
      if (state == SEND) begin
        timer <= '0;
      end else if (state == WAIT_DONE && !packet_done && !expire) begin
        timer <= timer + 1'b1;
      end
      if (expire && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
`else
  logic expire;
  assign expire     = 1'b0;
  assign drop_count = '0;
`endif

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE:      if (!fifo_empty) next_state = REQ;
      REQ:       if (permission_granted_send) next_state = SEND;
      SEND:      next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (packet_done || expire) begin
          fifo_pop   = 1'b1;
          next_state = IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid_out      <= 1'b0;
      data_out       <= '0;
      overflow_count <= '0;
    end else begin
      state     <= next_state;
      valid_out <= fire;
      if (fire) data_out <= fifo_head;
      // Fullness is sampled before this edge's pop, so a departing packet never frees a slot early.
      if (valid_in && fifo_full && overflow_count != '1) overflow_count <= overflow_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_onoc_net_iface.sv
// Directed bench for onoc_net_iface: handshake, overflow, grant stall, timeout and async reset.
module tb_onoc_net_iface;
  import packet_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  packet_t     data_in;
  logic        valid_in;
  logic        ready_out;
  logic        request_to_send;
  logic        permission_granted_send;
  logic        packet_done;
  packet_t     data_out;
  logic        valid_out;
  logic [2:0]  occupancy;
  logic [31:0] overflow_count;
  logic [31:0] drop_count;

  int passes = 0;
  int total  = 0;
  int vcnt   = 0;
  int vbase  = 0;

  onoc_net_iface #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .data_in                 (data_in),
    .valid_in                (valid_in),
    .ready_out               (ready_out),
    .request_to_send         (request_to_send),
    .permission_granted_send (permission_granted_send),
    .packet_done             (packet_done),
    .data_out                (data_out),
    .valid_out               (valid_out),
    .occupancy               (occupancy),
    .overflow_count          (overflow_count),
    .drop_count              (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid_out === 1'b1) vcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic packet_t mk(input logic [3:0] s);
    packet_t p;
    p.src     = s;
    p.dst     = 4'h5;
    p.payload = 32'hA500_0000 | 32'(s);
    return p;
  endfunction

  initial begin
    rst = 1'b1;
    data_in = '0;
    valid_in = 1'b0;
    permission_granted_send = 1'b0;
    packet_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", ready_out, 1);
    chk("rst_rts", request_to_send, 0);
    chk("rst_vld", valid_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_drop", drop_count, 0);

    // Single packet with grant held high
    permission_granted_send = 1'b1;
    data_in = mk(4'd2);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("t1_occ_push", occupancy, 1);
    chk("t1_rts_idle", request_to_send, 0);
    tick();
    chk("t1_rts_req", request_to_send, 1);
    chk("t1_vld_req", valid_out, 0);
    tick();
    chk("t1_vld_send", valid_out, 1);
    chk("t1_src_send", data_out.src, 2);
    chk("t1_pay_send", data_out.payload, 32'hA500_0002);
    tick();
    chk("t1_vld_wait", valid_out, 0);
    chk("t1_hold_src", data_out.src, 2);
    chk("t1_rts_wait", request_to_send, 1);
    chk("t1_occ_wait", occupancy, 1);
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    permission_granted_send = 1'b0;
    chk("t1_occ_done", occupancy, 0);
    chk("t1_rts_done", request_to_send, 0);
    chk("t1_vcnt", vcnt, 1);

    // Six back-to-back pushes into a depth-4 queue, no grant
    for (int i = 0; i < 6; i++) begin
      data_in = mk(4'(i + 1));
      valid_in = 1'b1;
      chk($sformatf("t2_ready_%0d", i), ready_out, (i < 4) ? 1 : 0);
      tick();
      if (i >= 1) chk($sformatf("t2_rts_%0d", i), request_to_send, 1);
    end
    valid_in = 1'b0;
    chk("t2_ovf", overflow_count, 2);
    chk("t2_occ", occupancy, 4);
    chk("t2_ready_full", ready_out, 0);

    // Grant withheld for 10 cycles, then given once
    vbase = vcnt;
    repeat (10) tick();
    chk("t3_vcnt_stall", vcnt, vbase);
    chk("t3_rts_stall", request_to_send, 1);
    permission_granted_send = 1'b1;
    tick();
    permission_granted_send = 1'b0;
    chk("t3_vld", valid_out, 1);
    chk("t3_src", data_out.src, 1);
    tick();
    chk("t3_vld_off", valid_out, 0);
    repeat (3) tick();
    chk("t3_vcnt_once", vcnt, vbase + 1);

    // Push at full in the same cycle packet_done pops the head
    data_in = mk(4'd7);
    valid_in = 1'b1;
    packet_done = 1'b1;
    tick();
    valid_in = 1'b0;
    packet_done = 1'b0;
    chk("t4_ovf", overflow_count, 3);
    chk("t4_occ", occupancy, DEPTH - 1);
    chk("t4_ready", ready_out, 1);

    // Next packet (src 2) reaches WAIT_DONE
    tick();
    permission_granted_send = 1'b1;
    tick();
    permission_granted_send = 1'b0;
    chk("t5_src", data_out.src, 2);
    tick();
`ifdef ONOC_NI_TIMEOUT_EN
    repeat (15) tick();
    chk("to_rts_pre", request_to_send, 1);
    chk("to_occ_pre", occupancy, 3);
    chk("to_drop_pre", drop_count, 0);
    tick();
    chk("to_drop", drop_count, 1);
    chk("to_occ", occupancy, 2);
    chk("to_rts_idle", request_to_send, 0);
    data_in = mk(4'd8);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("to_rts_next", request_to_send, 1);
    chk("to_occ_refill", occupancy, 3);
    permission_granted_send = 1'b1;
    tick();
    permission_granted_send = 1'b0;
    chk("to_src_next", data_out.src, 3);
    tick();
`else
    repeat (100) tick();
    chk("nto_rts", request_to_send, 1);
    chk("nto_occ", occupancy, 3);
    chk("nto_drop", drop_count, 0);
    chk("nto_vld", valid_out, 0);
`endif

    // Asynchronous reset in WAIT_DONE with 3 packets queued
    rst = 1'b1;
    #1;
    chk("ar_rts", request_to_send, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_vld", valid_out, 0);
    chk("ar_dout", data_out, 0);
    chk("ar_ovf", overflow_count, 0);
    chk("ar_drop", drop_count, 0);
    chk("ar_ready", ready_out, 1);
    rst = 1'b0;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    chk("ar_occ_post", occupancy, 0);
    chk("ar_rts_post", request_to_send, 0);
    tick();
    chk("ar_rts_post2", request_to_send, 0);
    chk("ar_drop_post", drop_count, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
